// File: rtl/frame_receiver_pkg.sv
// Shared types and constants for the link frame receiver: the payload layout,
// K-character codes, FSM state encoding and the bytewise CRC-8 step.
package frame_receiver_pkg;

  localparam int PAYLOAD_DATA_BYTES = 16;

  typedef struct packed {
    logic [7:0]                      payload_type;
    logic [PAYLOAD_DATA_BYTES*8-1:0] data;
  } payload_t;

  localparam logic [7:0] K_SOF     = 8'h3C;
  localparam logic [7:0] K_IDLE    = 8'hBC;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_TYPE  = 2'd1,
    ST_DATA  = 2'd2,
    ST_CHECK = 2'd3
  } rx_state_t;

  // MSB-first CRC-8 update, init 0, no reflection, no final XOR.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? CRC8_POLY : 8'h00);
    return c;
  endfunction

endpackage

// File: rtl/frame_receiver_if.sv
// Decoded symbol stream from the link decoder into the frame receiver.
interface frame_receiver_if;
  logic [7:0] rx_data_i;
  logic       rx_k_i;
  logic       rx_valid_i;
  logic       rx_err_i;

  modport master (output rx_data_i, rx_k_i, rx_valid_i, rx_err_i);
  modport slave  (input  rx_data_i, rx_k_i, rx_valid_i, rx_err_i);
endinterface

// File: rtl/frame_receiver.sv
// Assembles SOF|type|data|CRC frames from the symbol stream, checks CRC-8 and
// publishes good frames with a one-cycle tick; bad frames are dropped and counted.
module frame_receiver
  import frame_receiver_pkg::*;
#(
  parameter int DATA_BYTES  = PAYLOAD_DATA_BYTES,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  frame_receiver_if.slave  rx,
  output payload_t         payload_o,
  output logic             frame_tick_o,
  output logic             crc_err_o,
  output logic             frame_err_o,
  output logic [15:0]      good_count_o,
  output logic [15:0]      err_count_o
);

  localparam logic [1:0] HUNT  = ST_HUNT;
  localparam logic [1:0] TYPE  = ST_TYPE;
  localparam logic [1:0] DATA  = ST_DATA;
  localparam logic [1:0] CHECK = ST_CHECK;
  localparam int         BW    = $clog2(DATA_BYTES + 1);

  logic [1:0]              state, state_n;
  logic [7:0]              crc, crc_n;
  logic [7:0]              type_r, type_n;
  logic [DATA_BYTES*8-1:0] data_sr, sr_n;
  logic [BW-1:0]           byte_cnt, cnt_n;
  logic [15:0]             gap_cnt, gap_n;
  logic                    good, bad_crc, abort;
  logic [7:0]              d;

  assign d = rx.rx_data_i;

  always_comb begin
    state_n = state;
    crc_n   = crc;
    type_n  = type_r;
    sr_n    = data_sr;
    cnt_n   = byte_cnt;
    gap_n   = gap_cnt;
    good    = 1'b0;
    bad_crc = 1'b0;
    abort   = 1'b0;
    if (state != HUNT) begin
      if (!rx.rx_valid_i) begin
        // gap timer only runs while a frame is open
        if (gap_cnt == 16'(GAP_TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_n = HUNT;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt + 16'd1;
        end
      end else begin
        gap_n = '0;
        if (rx.rx_err_i) begin
          abort   = 1'b1;
          state_n = HUNT;
        end else if (rx.rx_k_i) begin
          abort = 1'b1;
          if (d == K_SOF) begin
            state_n = TYPE;
            crc_n   = 8'h00;
          end else begin
            state_n = HUNT;
          end
        end else begin
          case (state)
            TYPE: begin
              type_n  = d;
              crc_n   = crc8_next(crc, d);
              cnt_n   = '0;
              state_n = DATA;
            end
            DATA: begin
              sr_n  = {data_sr[DATA_BYTES*8-9:0], d};
              crc_n = crc8_next(crc, d);
              cnt_n = byte_cnt + BW'(1);
              if (byte_cnt == BW'(DATA_BYTES - 1)) state_n = CHECK;
            end
            CHECK: begin
              good    = (d == crc);
              bad_crc = (d != crc);
              state_n = HUNT;
            end
            default: state_n = HUNT;
          endcase
        end
      end
    end else if (rx.rx_valid_i && !rx.rx_err_i && rx.rx_k_i && d == K_SOF) begin
      state_n = TYPE;
      crc_n   = 8'h00;
      gap_n   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      crc          <= '0;
      type_r       <= '0;
      data_sr      <= '0;
      byte_cnt     <= '0;
      gap_cnt      <= '0;
      payload_o    <= '0;
      frame_tick_o <= 1'b0;
      crc_err_o    <= 1'b0;
      frame_err_o  <= 1'b0;
      good_count_o <= '0;
      err_count_o  <= '0;
    end else begin
      state        <= state_n;
      crc          <= crc_n;
      type_r       <= type_n;
      data_sr      <= sr_n;
      byte_cnt     <= cnt_n;
      gap_cnt      <= gap_n;
      frame_tick_o <= good;
      crc_err_o    <= bad_crc;
      frame_err_o  <= abort;
      if (good) begin
        payload_o.payload_type <= type_r;
        payload_o.data         <= data_sr;
        if (good_count_o != 16'hFFFF) good_count_o <= good_count_o + 16'd1;
      end
      if ((bad_crc || abort) && err_count_o != 16'hFFFF)
        err_count_o <= err_count_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// Randomised scoreboard bench for frame_receiver: the driver pushes the outcome
// each frame must produce; a negedge monitor pops and checks every strobe.
module tb_frame_receiver;
  import frame_receiver_pkg::*;

  localparam int GT = 4;
  localparam int NB = PAYLOAD_DATA_BYTES;
  localparam int K_GOOD = 0, K_CRC = 1, K_FRM = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_receiver_if rxi();
  payload_t    payload;
  logic        tick, crc_err, frame_err;
  logic [15:0] good_cnt, err_cnt;

  frame_receiver #(.DATA_BYTES(NB), .GAP_TIMEOUT(GT)) dut (
    .clk(clk), .reset(reset), .rx(rxi),
    .payload_o(payload), .frame_tick_o(tick), .crc_err_o(crc_err),
    .frame_err_o(frame_err), .good_count_o(good_cnt), .err_count_o(err_cnt)
  );

  typedef struct { int kind; int cyc; payload_t p; } exp_t;
  exp_t     q[$];
  exp_t     me;
  int       total = 0, bad = 0;
  int       cyc = 0, sent_cyc = 0;
  payload_t last_good;
  int       n_good, n_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic chk_p(input string n, input payload_t act, input payload_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", n, act, exp, cyc);
    end
  endtask

  // CRC as remainder of the zero-augmented message divided by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [7:0] m [0:NB]);
    logic [8:0] r;
    r = '0;
    for (int i = 0; i <= NB + 1; i++)
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], (i <= NB) ? m[i][b] : 1'b0};
        if (r[8]) r = r ^ 9'h107;
      end
    return r[7:0];
  endfunction

  task automatic sym(input logic [7:0] d, input logic k, input logic e);
    rxi.rx_data_i  = d;
    rxi.rx_k_i     = k;
    rxi.rx_err_i   = e;
    rxi.rx_valid_i = 1'b1;
    sent_cyc = cyc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rxi.rx_data_i  = 8'($urandom);
      rxi.rx_k_i     = 1'($urandom);
      rxi.rx_err_i   = 1'($urandom);
      rxi.rx_valid_i = 1'b0;
      sent_cyc = cyc;
      @(posedge clk); #1;
    end
    rxi.rx_valid_i = 1'b0;
  endtask

  task automatic comma(input int n);
    for (int i = 0; i < n; i++) sym(K_IDLE, 1'b1, 1'b0);
  endtask

  task automatic push(input int kind, input int c, input payload_t p);
    exp_t e;
    e.kind = kind; e.cyc = c; e.p = p;
    q.push_back(e);
  endtask

  // fault: 0 none, 1 bad CRC, 2 comma, 3 SOF, 4 rx_err, 5 full gap, 6 gap one short
  task automatic frame(input logic [7:0] typ, input logic [NB*8-1:0] dat,
                       input int fault, input int pos, input bit skip_sof, input bit gaps);
    logic [7:0] m [0:NB];
    logic [7:0] c;
    payload_t   p;
    m[0] = typ;
    for (int i = 1; i <= NB; i++) m[i] = dat[(NB-i)*8 +: 8];
    c = ref_crc(m);
    if (fault == 1) c = c ^ 8'h01;
    p.payload_type = typ;
    p.data         = dat;
    if (!skip_sof) sym(K_SOF, 1'b1, 1'b0);
    for (int i = 0; i <= NB + 1; i++) begin
      if (i == pos && fault >= 2 && fault <= 5) begin
        case (fault)
          2:       sym(K_IDLE, 1'b1, 1'b0);
          3:       sym(K_SOF, 1'b1, 1'b0);
          4:       sym(8'($urandom), 1'($urandom), 1'b1);
          default: idle(GT);
        endcase
        push(K_FRM, sent_cyc + 1, '0);
        return;
      end
      if (i == pos && fault == 6) idle(GT - 1);
      else if (gaps) idle($urandom_range(0, GT - 1));
      sym((i <= NB) ? m[i] : c, 1'b0, 1'b0);
    end
    push((fault == 1) ? K_CRC : K_GOOD, sent_cyc + 1, p);
  endtask

  function automatic logic [NB*8-1:0] rnd_data();
    logic [NB*8-1:0] v;
    for (int i = 0; i < NB / 4; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (tick || crc_err || frame_err) begin
        chk_i("strobe_exclusive", int'(tick) + int'(crc_err) + int'(frame_err), 1);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_strobe: got tick=%0d crc=%0d frm=%0d expected none (cyc %0d)",
                   tick, crc_err, frame_err, cyc);
        end else begin
          me = q.pop_front();
          chk_i("kind", tick ? K_GOOD : (crc_err ? K_CRC : K_FRM), me.kind);
          chk_i("latency", cyc, me.cyc);
          if (me.kind == K_GOOD) begin
            n_good++;
            last_good = me.p;
          end else begin
            n_err++;
          end
          chk_p("payload", payload, last_good);
          chk_i("good_count", int'(good_cnt), n_good);
          chk_i("err_count", int'(err_cnt), n_err);
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        me = q.pop_front();
        total++; bad++;
        $display("FAIL missing_strobe: got none expected kind %0d at cyc %0d (now %0d)",
                 me.kind, me.cyc, cyc);
      end
    end
  end

  initial begin
    int f, pos;
    rxi.rx_data_i = '0; rxi.rx_k_i = 1'b0; rxi.rx_err_i = 1'b0; rxi.rx_valid_i = 1'b0;
    last_good = '0; n_good = 0; n_err = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_p("reset_payload", payload, '0);
    chk_i("reset_strobes", int'({tick, crc_err, frame_err}), 0);
    chk_i("reset_good_count", int'(good_cnt), 0);
    chk_i("reset_err_count", int'(err_cnt), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    comma(3);

    frame(8'h01, 128'h5, 0, 0, 1'b0, 1'b0); comma(2);
    frame(8'h01, 128'h5, 1, 0, 1'b0, 1'b0); comma(2);
    frame(8'h07, rnd_data(), 2, 6, 1'b0, 1'b0);
    frame(8'h02, rnd_data(), 0, 0, 1'b0, 1'b0); comma(1);
    frame(8'h09, rnd_data(), 3, 10, 1'b0, 1'b0);
    frame(8'h01, rnd_data(), 0, 0, 1'b1, 1'b0); comma(1);
    frame(8'h02, rnd_data(), 6, 8, 1'b0, 1'b0); comma(1);
    frame(8'h02, rnd_data(), 5, 8, 1'b0, 1'b0); comma(1);
    frame(8'h02, rnd_data(), 0, 0, 1'b0, 1'b0);
    frame(8'h01, rnd_data(), 0, 0, 1'b0, 1'b0);
    comma(3);

    sym(K_SOF, 1'b1, 1'b0);
    sym(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) sym(8'($urandom), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk_p("midframe_reset_payload", payload, '0);
    chk_i("midframe_reset_good_count", int'(good_cnt), 0);
    chk_i("midframe_reset_err_count", int'(err_cnt), 0);
    last_good = '0; n_good = 0; n_err = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    comma(2);
    frame(8'h01, rnd_data(), 0, 0, 1'b0, 1'b0); comma(2);

    for (int it = 0; it < 200; it++) begin
      f   = $urandom_range(0, 9);
      if (f > 6) f = 0;
      pos = $urandom_range(0, NB + 1);
      frame(8'($urandom_range(1, 2)), rnd_data(), f, pos, 1'b0, 1'($urandom));
      if (f == 3) frame(8'($urandom), rnd_data(), 0, 0, 1'b1, 1'($urandom));
      comma($urandom_range(0, 2));
      idle($urandom_range(0, 6));
    end

    comma(3);
    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    chk_i("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
